// File: rtl/spi_slave_rx_pkg.sv
// Shared SPI definitions: FSM encoding and default frame width.
// The master controller imports the same package.
package spi_slave_rx_pkg;

    localparam int SPI_DW = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for one asynchronous input.
// Also produces single-cycle rise/fall pulses on the synchronised level.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   level_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            chain   <= {SYNC_STAGES{RESET_VAL}};
            level_d <= RESET_VAL;
        end else begin
            chain   <= {chain[SYNC_STAGES-2:0], din};
            level_d <= chain[SYNC_STAGES-1];
        end
    end

    assign level = chain[SYNC_STAGES-1];
    assign rise  = level & ~level_d;
    assign fall  = ~level & level_d;

endmodule

// File: rtl/spi_slave_rx.sv
// Mode-0 SPI slave: deserialises DATA_WIDTH-bit frames from an oversampled SCK
// and shifts a preloaded response word out on MISO in the same frame.
//
// state    | meaning
// ST_IDLE  | cs_n high, waiting for a cs_n fall; miso held at 0
// ST_SHIFT | frame in progress, counting sck rises
// ST_DONE  | one cycle: publish rx_data, then reload or go idle
module spi_slave_rx
    import spi_slave_rx_pkg::*;
#(
    parameter int DATA_WIDTH  = SPI_DW,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sck,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int              CW       = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0]   LAST_BIT = CW'(DATA_WIDTH - 1);

    spi_state_t state, state_nxt;

    logic                   sck_lvl_unused, sck_rise, sck_fall;
    logic                   cs_lvl, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   mosi_s;

    logic [CW-1:0]          bit_cnt;
    logic [DATA_WIDTH-1:0]  rx_shift;
    logic [DATA_WIDTH-1:0]  tx_shift;

    logic load_tx, shift_rx, shift_tx, clear_tx, done, abort, abort_err, last_rise;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
        .clk   (clk),
        .reset (reset),
        .din   (sck),
        .level (sck_lvl_unused),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk   (clk),
        .reset (reset),
        .din   (cs_n),
        .level (cs_lvl),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    // Same depth as the sck path so the sampled bit lines up with sck_rise.
    always_ff @(posedge clk) begin
        if (!reset) mosi_sync <= '0;
        else        mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
    end
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign last_rise = sck_rise && (bit_cnt == LAST_BIT);

    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (cs_fall) state_nxt = ST_SHIFT;
            ST_SHIFT: begin
                if (last_rise)    state_nxt = ST_DONE;
                else if (cs_rise) state_nxt = ST_IDLE;
            end
            ST_DONE:  state_nxt = cs_lvl ? ST_IDLE : ST_SHIFT;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        load_tx   = 1'b0;
        shift_rx  = 1'b0;
        shift_tx  = 1'b0;
        clear_tx  = 1'b0;
        done      = 1'b0;
        abort     = 1'b0;
        abort_err = 1'b0;
        case (state)
            ST_IDLE:  load_tx = cs_fall;
            ST_SHIFT: begin
                busy     = 1'b1;
                shift_rx = sck_rise;
                // bit_cnt==0 here means the fall belongs to the previous frame's last bit
                shift_tx = sck_fall && (bit_cnt != '0);
                // a final rise wins over a simultaneous cs_n rise
                abort     = cs_rise && !last_rise;
                abort_err = (bit_cnt != '0) || sck_rise;
            end
            ST_DONE: begin
                done     = 1'b1;
                load_tx  = !cs_lvl;
                clear_tx = cs_lvl;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            bit_cnt   <= '0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (shift_rx) begin
                rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
                bit_cnt  <= bit_cnt + CW'(1);
            end
            if (done) begin
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
                bit_cnt  <= '0;
            end
            if (load_tx) begin
                tx_shift <= tx_data;
                bit_cnt  <= '0;
            end else if (shift_tx) begin
                tx_shift <= tx_shift << 1;
            end else if (clear_tx) begin
                tx_shift <= '0;
            end
            if (abort) begin
                bit_cnt   <= '0;
                tx_shift  <= '0;
                frame_err <= abort_err;
            end
        end
    end

    assign miso = tx_shift[DATA_WIDTH-1];

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: a mode-0 master model at clk/8 with
// hand-computed expected words, pulse counts and rx_valid latency.
module tb_spi_slave_rx;

    logic        clk = 1'b0;
    logic        reset, sck, cs_n, mosi, miso;
    logic [15:0] tx_data, rx_data;
    logic        rx_valid, frame_err, busy;

    int passed = 0;
    int total  = 0;

    int valid_cnt = 0, err_cnt = 0, valid_run = 0, err_run = 0;
    int max_valid_run = 0, max_err_run = 0, idle_viol = 0;
    bit watch_idle = 1'b0;

    logic [15:0] miso_cap;
    logic        valid_at_last;
    logic [15:0] rx_at_last;

    spi_slave_rx #(.DATA_WIDTH(16), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .sck       (sck),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .miso      (miso),
        .tx_data   (tx_data),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            valid_cnt++;
            valid_run++;
            if (valid_run > max_valid_run) max_valid_run = valid_run;
        end else valid_run = 0;
        if (frame_err === 1'b1) begin
            err_cnt++;
            err_run++;
            if (err_run > max_err_run) max_err_run = err_run;
        end else err_run = 0;
        if (watch_idle && (busy !== 1'b0 || miso !== 1'b0 || rx_valid !== 1'b0))
            idle_viol++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, observed hang expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [15:0] w, input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            mosi = w[15-i];
            wait_clk(4);
            sck = 1'b1;
            miso_cap = {miso_cap[14:0], miso};
            wait_clk(4);
            if (i == 15) begin
                valid_at_last = rx_valid;
                rx_at_last    = rx_data;
            end
            sck = 1'b0;
        end
    endtask

    task automatic cs_fall_start();
        cs_n = 1'b0;
        wait_clk(4);
    endtask

    task automatic cs_raise();
        wait_clk(4);
        cs_n = 1'b1;
        wait_clk(8);
    endtask

    initial begin
        reset   = 1'b0;
        sck     = 1'b0;
        cs_n    = 1'b1;
        mosi    = 1'b0;
        tx_data = 16'h0000;
        miso_cap = '0;

        // 1: reset and idle
        wait_clk(3);
        check("reset_rx_data",   32'(rx_data),   32'h0);
        check("reset_rx_valid",  32'(rx_valid),  32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        check("reset_busy",      32'(busy),      32'h0);
        check("reset_miso",      32'(miso),      32'h0);
        reset = 1'b1;
        wait_clk(10);
        check("idle_busy",      32'(busy),      32'h0);
        check("idle_miso",      32'(miso),      32'h0);
        check("idle_pulses",    32'(valid_cnt + err_cnt), 32'h0);

        // 2: single frame
        tx_data = 16'hA55A;
        cs_fall_start();
        check("frame_busy", 32'(busy), 32'h1);
        send_bits(16'h3C5F, 0, 16);
        check("frame_latency", 32'(valid_at_last), 32'h1);
        check("frame_rx_data", 32'(rx_at_last),    32'h3C5F);
        cs_raise();
        check("frame_miso_word", 32'(miso_cap), 32'hA55A);
        check("frame_valid_cnt", 32'(valid_cnt), 32'd1);
        check("frame_valid_width", 32'(max_valid_run), 32'd1);
        check("frame_busy_after", 32'(busy), 32'h0);

        // 3: back-to-back frames; tx_data change mid-frame only affects the reload
        tx_data = 16'hC3C3;
        cs_fall_start();
        send_bits(16'h0001, 0, 8);
        tx_data = 16'h1357;
        send_bits(16'h0001, 8, 8);
        check("b2b1_latency", 32'(valid_at_last), 32'h1);
        check("b2b1_rx_data", 32'(rx_at_last),    32'h0001);
        check("b2b1_miso_word", 32'(miso_cap),    32'hC3C3);
        send_bits(16'hFFFF, 0, 16);
        check("b2b2_latency", 32'(valid_at_last), 32'h1);
        check("b2b2_rx_data", 32'(rx_at_last),    32'hFFFF);
        check("b2b2_miso_word", 32'(miso_cap),    32'h1357);
        cs_raise();
        check("b2b_valid_cnt", 32'(valid_cnt), 32'd3);
        check("b2b_no_err",    32'(err_cnt),   32'd0);

        // 4: abort after 9 bits
        tx_data = 16'h5555;
        cs_fall_start();
        send_bits(16'h1234, 0, 9);
        cs_raise();
        check("abort_err_cnt",   32'(err_cnt),     32'd1);
        check("abort_err_width", 32'(max_err_run), 32'd1);
        check("abort_valid_cnt", 32'(valid_cnt),   32'd3);
        check("abort_rx_data",   32'(rx_data),     32'hFFFF);
        check("abort_busy",      32'(busy),        32'h0);
        check("abort_miso",      32'(miso),        32'h0);

        // 5: reset mid-frame, then a clean frame
        tx_data = 16'h0F0F;
        cs_fall_start();
        send_bits(16'hDEAD, 0, 5);
        reset = 1'b0;
        wait_clk(3);
        cs_n = 1'b1;
        wait_clk(4);
        reset = 1'b1;
        wait_clk(6);
        check("rst_mid_valid_cnt", 32'(valid_cnt), 32'd3);
        check("rst_mid_err_cnt",   32'(err_cnt),   32'd1);
        check("rst_mid_rx_data",   32'(rx_data),   32'h0);
        check("rst_mid_busy",      32'(busy),      32'h0);
        cs_fall_start();
        send_bits(16'hBEEF, 0, 16);
        cs_raise();
        check("post_rst_rx_data",   32'(rx_data),   32'hBEEF);
        check("post_rst_miso_word", 32'(miso_cap),  32'h0F0F);
        check("post_rst_valid_cnt", 32'(valid_cnt), 32'd4);

        // 6: sck activity with cs_n high is ignored
        watch_idle = 1'b1;
        for (int k = 0; k < 20; k++) begin
            sck = 1'b1;
            wait_clk(2);
            sck = 1'b0;
            wait_clk(2);
        end
        wait_clk(6);
        watch_idle = 1'b0;
        check("cs_high_idle_viol", 32'(idle_viol), 32'd0);
        check("cs_high_valid_cnt", 32'(valid_cnt), 32'd4);
        check("cs_high_err_cnt",   32'(err_cnt),   32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
